incdec_arb: RTL and testbench

INCDEC_ARB -- requirements
Module: incdec_arb

---
 rtl/incdec_pkg.sv | 27 ++
 rtl/incdec_alu.sv | 37 +++
 rtl/incdec_arb.sv | 147 ++++++++++++++
 tb/tb_incdec_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/incdec_pkg.sv
// ============================================================================
//  Module : incdec_pkg
//  Shared nibble/result typedefs, op-code enum and result packing helper.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package incdec_pkg;

    typedef logic [3:0]  u4;
    typedef logic [11:0] u12;

    typedef enum logic [1:0] {
        OP_POSTINC_XOR = 2'd0,
        OP_POSTDEC_ADD = 2'd1,
        OP_PREINC_OR   = 2'd2,
        OP_PREDEC_AND  = 2'd3
    } op_e;

    // Packed layout is {a', b', r}.
    function automatic u12 pack_result(input u4 a_new, input u4 b_new, input u4 r);
        return {a_new, b_new, r};
    endfunction

endpackage

`default_nettype wire

// File: rtl/incdec_alu.sv
// ============================================================================
//  Module : incdec_alu
//  Combinational inc/dec nibble datapath producing the packed {a', b', r}.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module incdec_alu
    import incdec_pkg::*;
(
    input  op_e        op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [11:0] result
);

    u4 a_inc, b_inc, a_dec, b_dec;

    assign a_inc = a + 4'd1;
    assign b_inc = b + 4'd1;
    assign a_dec = a - 4'd1;
    assign b_dec = b - 4'd1;

    always_comb begin
        result = '0;
        case (op)
            OP_POSTINC_XOR: result = pack_result(a_inc, b_inc, a ^ b);
            OP_POSTDEC_ADD: result = pack_result(a_dec, b_dec, a + b);
            OP_PREINC_OR:   result = pack_result(a_inc, b_inc, a_inc | b_inc);
            OP_PREDEC_AND:  result = pack_result(a_dec, b_dec, a_dec & b_dec);
            default:        result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/incdec_arb.sv
// ============================================================================
//  Module : incdec_arb
//  Two-requester round-robin front end to a shared inc/dec ALU, results
//  buffered in a 2-entry FIFO. Optional per-source pop counters are built
//  when INCDEC_ARB_STATS_EN is defined.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module incdec_arb
    import incdec_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [3:0]  req0_a,
    input  logic [3:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [3:0]  req1_a,
    input  logic [3:0]  req1_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic        out_src,
    output logic [1:0]  out_op
`ifdef INCDEC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic       prio;
    logic [1:0] count;
    logic       wr_ptr;
    logic       rd_ptr;
    u12         mem_data [2];
    logic       mem_src  [2];
    logic [1:0] mem_op   [2];

    logic       full;
    logic       pop;
    logic       push;
    logic       can_push;
    logic       grant0;
    logic       grant1;
    logic       sel_src;
    logic [1:0] sel_op;
    u4          sel_a;
    u4          sel_b;
    u12         alu_result;

    assign full      = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    // When full, a grant is only possible because the head leaves this cycle.
    assign can_push  = rst_n && (!full || out_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_push) begin
            if (req0_valid && req1_valid) begin
                grant0 = !prio;
                grant1 = prio;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign push       = grant0 || grant1;
    assign sel_src    = grant1;
    assign sel_op     = grant1 ? req1_op : req0_op;
    assign sel_a      = grant1 ? req1_a  : req0_a;
    assign sel_b      = grant1 ? req1_b  : req0_b;

    incdec_alu u_alu (
        .op     (op_e'(sel_op)),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio   <= 1'b0;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                prio   <= ~sel_src;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= alu_result;
            mem_src[wr_ptr]  <= sel_src;
            mem_op[wr_ptr]   <= sel_op;
        end
    end

    assign out_data = mem_data[rd_ptr];
    assign out_src  = mem_src[rd_ptr];
    assign out_op   = mem_op[rd_ptr];

`ifdef INCDEC_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (pop) begin
            if (!out_src && (cnt0 != '1)) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (out_src && (cnt1 != '1)) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_incdec_arb.sv
// ============================================================================
//  Module : tb_incdec_arb
//  Directed self-checking bench for incdec_arb (stats checks need
//  INCDEC_ARB_STATS_EN).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_incdec_arb;

`ifdef INCDEC_ARB_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_op;
    logic [3:0]  req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_op;
    logic [3:0]  req1_a, req1_b;
    logic        out_valid, out_ready;
    logic [11:0] out_data;
    logic        out_src;
    logic [1:0]  out_op;
`ifdef INCDEC_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    incdec_arb #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_op     (out_op)
`ifdef INCDEC_ARB_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        if (k == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Vector table: requester, op, a, b, expected packed result.
    int          v_req [3] = '{0, 1, 0};
    logic [1:0]  v_op  [3] = '{2'd1, 2'd2, 2'd3};
    logic [3:0]  v_a   [3] = '{4'h0, 4'hF, 4'h0};
    logic [3:0]  v_b   [3] = '{4'h0, 4'h1, 4'h8};
    logic [11:0] v_exp [3] = '{12'hFF0, 12'h022, 12'hF77};

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b0;
        req0_valid = 1'b0; req0_op = 2'd0; req0_a = 4'h0; req0_b = 4'h0;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = 4'h0; req1_b = 4'h0;

        // Reset state
        repeat (2) tick();
        req0_valid = 1'b1;
        out_ready  = 1'b1;
        #1;
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
`ifdef INCDEC_ARB_STATS_EN
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
`endif
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic op0 with one-cycle latency
        drive(0, 2'd0, 4'h3, 4'h5);
        #1;
        check("op0_ready0", req0_ready, 1'b1);
        check("op0_empty_before", out_valid, 1'b0);
        tick();
        req0_valid = 1'b0;
        check("op0_out_valid", out_valid, 1'b1);
        check("op0_data", out_data, 12'h466);
        check("op0_src", out_src, 1'b0);
        check("op0_op", out_op, 2'd0);

        // Remaining op codes
        for (int i = 0; i < 3; i++) begin
            drive(v_req[i], v_op[i], v_a[i], v_b[i]);
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            check($sformatf("vec%0d_data", i), out_data, v_exp[i]);
            check($sformatf("vec%0d_src", i), out_src, v_req[i]);
            check($sformatf("vec%0d_op", i), out_op, v_op[i]);
        end
        tick();
        check("drain_valid", out_valid, 1'b0);

        // Round robin with both requesters permanently valid
        pulse_reset();
        tick();
        drive(0, 2'd0, 4'h1, 4'h1);
        drive(1, 2'd1, 4'h2, 4'h3);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr%0d_ready0", i), req0_ready, (i % 2) == 0);
            check($sformatf("rr%0d_ready1", i), req1_ready, (i % 2) == 1);
            tick();
            check($sformatf("rr%0d_src", i), out_src, i % 2);
        end

        // Back-pressure: two grants fill the FIFO, then stall
        req0_valid = 1'b0; req1_valid = 1'b0;
        pulse_reset();
        tick();
        out_ready = 1'b0;
        drive(0, 2'd0, 4'h1, 4'h1);
        drive(1, 2'd1, 4'h2, 4'h3);
        #1;
        check("bp_g1_ready0", req0_ready, 1'b1);
        check("bp_g1_ready1", req1_ready, 1'b0);
        tick();
        check("bp_g2_ready1", req1_ready, 1'b1);
        check("bp_g2_ready0", req0_ready, 1'b0);
        tick();
        check("bp_full_ready0", req0_ready, 1'b0);
        check("bp_full_ready1", req1_ready, 1'b0);
        check("bp_head_data", out_data, 12'h220);
        check("bp_head_src", out_src, 1'b0);
        tick();
        check("bp_stall_head", out_data, 12'h220);
        out_ready = 1'b1;
        #1;
        check("bp_pp_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("bp_order_data", out_data, 12'h125);
        check("bp_order_src", out_src, 1'b1);
        tick();
        check("bp_third_data", out_data, 12'h220);
        check("bp_third_src", out_src, 1'b0);
        tick();
        check("bp_empty", out_valid, 1'b0);

        // Reset mid-operation with a full FIFO
        out_ready = 1'b0;
        drive(0, 2'd0, 4'h1, 4'h1);
        drive(1, 2'd1, 4'h2, 4'h3);
        tick();
        tick();
        check("mr_full_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_ready0", req0_ready, 1'b0);
        check("mr_ready1", req1_ready, 1'b0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mr_first_ready0", req0_ready, 1'b1);
        check("mr_first_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("mr_first_src", out_src, 1'b0);
        check("mr_first_data", out_data, 12'h220);
        tick();
        check("mr_drain_data", out_data, 12'h125);
        tick();
        check("mr_drained", out_valid, 1'b0);

`ifdef INCDEC_ARB_STATS_EN
        // Saturating pop counter for source 1
        pulse_reset();
        tick();
        out_ready = 1'b1;
        drive(1, 2'd2, 4'hF, 4'h1);
        repeat (5) tick();
        req1_valid = 1'b0;
        repeat (2) tick();
        check("stats_cnt1", cnt1, 3);
        check("stats_cnt0", cnt0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
